// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Define DCACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module data_cache #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned IDX_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic             a_type,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic             inv,
    output logic [WIDTH-1:0] rdata,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
`endif
);
    localparam int unsigned LINES = 2**IDX_BITS;
    localparam int unsigned TAG_W = WIDTH - IDX_BITS - 2;
    localparam int unsigned LANES = WIDTH / 8;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR} state_t;

    state_t              state_q, state_d;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [WIDTH-1:0]    data_q [LINES];

    logic [IDX_BITS-1:0] idx;
    logic [TAG_W-1:0]    tag;
    logic [1:0]          lane;
    logic                hit;
    logic [WIDTH-1:0]    line_rd;
    logic [WIDTH-1:0]    line_wdata;
    logic                line_we;
    logic                fill_valid;
    logic [3:0]          byte_be;

    function automatic logic [WIDTH-1:0] load_fmt(input logic [WIDTH-1:0] w,
                                                  input logic byte_acc,
                                                  input logic [1:0] l);
        return byte_acc ? WIDTH'(w[{l, 3'b000} +: 8]) : w;
    endfunction

    assign idx       = req_addr[IDX_BITS+1:2];
    assign tag       = req_addr[WIDTH-1:IDX_BITS+2];
    assign lane      = req_addr[1:0];
    assign line_rd   = data_q[idx];
    assign hit       = valid_q[idx] && (tag_q[idx] == tag) && !inv;
    assign byte_be   = 4'b0001 << lane;
    assign mem_addr  = {req_addr[WIDTH-1:2], 2'b00};
    assign mem_wdata = a_type ? {LANES{req_wdata[7:0]}} : req_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake outputs and line-write control
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        rdata      = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        line_we    = 1'b0;
        line_wdata = line_rd;
        fill_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_we) begin
                        stall   = 1'b1;
                        state_d = WR;
                    end else if (hit) begin
                        rdata = load_fmt(line_rd, a_type, lane);
                    end else begin
                        stall   = 1'b1;
                        state_d = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                mem_req = 1'b1;
                mem_be  = 4'b1111;
                stall   = !mem_ack;
                if (mem_ack) begin
                    rdata      = load_fmt(mem_rdata, a_type, lane);
                    line_we    = 1'b1;
                    line_wdata = mem_rdata;
                    fill_valid = !inv;
                    state_d    = IDLE;
                end
            end
            WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                mem_be  = a_type ? byte_be : 4'b1111;
                stall   = !mem_ack;
                if (mem_ack) begin
                    line_we = hit;
                    if (a_type) begin
                        line_wdata[{lane, 3'b000} +: 8] = req_wdata[7:0];
                    end else begin
                        line_wdata = req_wdata;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The CPU may still present a request while reset is held
        if (!rst) begin
            stall = 1'b0;
            rdata = '0;
        end
    end

    // Invalidate wins over a same-cycle fill
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (inv) begin
            valid_q <= '0;
        end else if (fill_valid) begin
            valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= line_wdata;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state_q == IDLE && req_valid && !req_we && hit && hit_count != '1) begin
                hit_count <= hit_count + 32'd1;
            end
            if (state_q == RD_MISS && mem_ack && miss_count != '1) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache: a coherent word-memory model plus a line-occupancy
// table predicts hit/miss, load data, and every backing-memory request field.
module tb_data_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, a_type, inv;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] rdata;
    logic        stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    data_cache dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .a_type    (a_type),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .inv       (inv),
        .rdata     (rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] bmem [int unsigned];
    logic [31:0] line_word [16];
    bit          line_ok [16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_mem(input logic [31:0] w);
        if (!bmem.exists(w)) bmem[w] = $urandom;
        return bmem[w];
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] addr, input bit byt);
        logic [31:0] word;
        word = get_mem(addr >> 2);
        return byt ? ((word >> (8 * addr[1:0])) & 32'hFF) : word;
    endfunction

    task automatic clear_lines();
        for (int i = 0; i < 16; i++) line_ok[i] = 1'b0;
    endtask

    // Idle cycle between accesses: no request means no stall and zero rdata
    task automatic idle_step();
        @(negedge clk);
        req_valid = 1'b0; mem_ack = 1'b0; inv = 1'b0;
        #1;
        check_eq("idle_stall", stall, 0);
        check_eq("idle_rdata", rdata, 0);
        check_eq("idle_memreq", mem_req, 0);
    endtask

    // lat < 0 picks a random number of non-ack cycles
    task automatic access(input bit we, input bit byt, input logic [31:0] addr,
                          input logic [31:0] wd, input int lat, input bit inv_at_ack,
                          output int stalls);
        logic [31:0] w, word, exp_wd;
        logic [3:0]  exp_be;
        int          idx, n;
        bit          exp_hit;
        w       = addr >> 2;
        idx     = int'(w % 16);
        exp_hit = line_ok[idx] && (line_word[idx] == w);
        exp_wd  = byt ? {4{wd[7:0]}} : wd;
        exp_be  = byt ? (4'b0001 << addr[1:0]) : 4'b1111;
        stalls  = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; a_type = byt; req_addr = addr; req_wdata = wd;
        mem_ack = 1'b0; inv = 1'b0;
        #1;
        if (!we && exp_hit) begin
            check_eq("hit_stall", stall, 0);
            check_eq("hit_rdata", rdata, exp_load(addr, byt));
            check_eq("hit_memreq", mem_req, 0);
        end else begin
            check_eq("first_stall", stall, 1);
            check_eq("first_memreq", mem_req, 0);
            stalls = 1;
            n = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
            for (int c = 0; c <= n; c++) begin
                @(negedge clk);
                mem_ack   = (c == n);
                mem_rdata = mem_ack ? get_mem(w) : $urandom;
                inv       = inv_at_ack && mem_ack;
                #1;
                check_eq("memreq", mem_req, 1);
                check_eq("memwe", mem_we, we);
                check_eq("memaddr", mem_addr, w << 2);
                check_eq("membe", mem_be, we ? exp_be : 4'b1111);
                if (we) check_eq("memwdata", mem_wdata, exp_wd);
                check_eq("xfer_stall", stall, !mem_ack);
                if (!mem_ack) stalls++;
                if (mem_ack && !we) check_eq("fill_rdata", rdata, exp_load(addr, byt));
            end
            if (we) begin
                word = get_mem(w);
                for (int b = 0; b < 4; b++) if (exp_be[b]) word[8*b +: 8] = exp_wd[8*b +: 8];
                bmem[w] = word;
            end else if (inv_at_ack) begin
                clear_lines();
            end else begin
                line_ok[idx]   = 1'b1;
                line_word[idx] = w;
            end
        end
        idle_step();
    endtask

    task automatic pulse_inv();
        @(negedge clk);
        req_valid = 1'b0; inv = 1'b1;
        #1;
        check_eq("inv_stall", stall, 0);
        @(negedge clk);
        inv = 1'b0;
        clear_lines();
    endtask

    int          st;
    logic [31:0] addr, last_addr;
    bit          we, byt;

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; a_type = 1'b0; inv = 1'b0;
        req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        clear_lines();
        #12;
        check_eq("rst_stall", stall, 0);
        check_eq("rst_memreq", mem_req, 0);
        check_eq("rst_memwe", mem_we, 0);
        check_eq("rst_membe", mem_be, 0);
        check_eq("rst_rdata", rdata, 0);
        req_valid = 1'b1; req_addr = 32'h40;
        #1;
        check_eq("rst_req_stall", stall, 0);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;

        // Cold miss with three wait cycles, then a zero-latency hit
        bmem[32'h10] = 32'h1234_5678;
        access(0, 0, 32'h40, 0, 3, 0, st);
        check_eq("coldmiss_stalls", st, 4);
        access(0, 0, 32'h40, 0, 0, 0, st);
        check_eq("rehit_stalls", st, 0);
`ifdef DCACHE_STATS_EN
        check_eq("hit_count", hit_count, 1);
        check_eq("miss_count", miss_count, 1);
`endif
        // Write-through store updating a resident line
        access(1, 0, 32'h40, 32'hDEAD_BEEF, 1, 0, st);
        access(0, 0, 32'h40, 0, 0, 0, st);
        check_eq("store_then_hit", st, 0);
        // Byte store and byte load
        access(1, 1, 32'h43, 32'h0000_00AB, 0, 0, st);
        access(0, 1, 32'h43, 0, 0, 0, st);
        check_eq("byte_hit_stalls", st, 0);
        // Conflict eviction on the same index
        access(0, 0, 32'h80, 0, 1, 0, st);
        check_eq("conflict_miss", st > 0, 1);
        access(0, 0, 32'h40, 0, 1, 0, st);
        check_eq("evicted_miss", st > 0, 1);
        // Invalidate-all
        pulse_inv();
        access(0, 0, 32'h40, 0, 2, 0, st);
        check_eq("inv_miss", st > 0, 1);
        // Invalidate on the fill-ack cycle must not leave the line valid
        access(0, 0, 32'h80, 0, 1, 1, st);
        access(0, 0, 32'h80, 0, 1, 0, st);
        check_eq("inv_ack_miss", st > 0, 1);
        // Reset in the middle of a refill
        pulse_inv();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; a_type = 1'b0; req_addr = 32'h40;
        #1;
        check_eq("rm_first_stall", stall, 1);
        @(negedge clk);
        #1;
        check_eq("rm_memreq", mem_req, 1);
        rst = 1'b0;
        #1;
        check_eq("rm_rst_memreq", mem_req, 0);
        check_eq("rm_rst_stall", stall, 0);
        check_eq("rm_rst_membe", mem_be, 0);
        check_eq("rm_rst_rdata", rdata, 0);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        clear_lines();
        access(0, 0, 32'h40, 0, 1, 0, st);
        check_eq("post_rst_miss", st > 0, 1);

        // Random traffic over four tags per index with frequent reuse
        last_addr = 32'h40;
        for (int i = 0; i < 400; i++) begin
            we   = ($urandom_range(0, 3) == 0);
            byt  = ($urandom_range(0, 2) == 0);
            addr = ($urandom_range(0, 1) == 0) ? last_addr : 32'($urandom_range(0, 255));
            if (!byt) addr[1:0] = 2'b00;
            if ($urandom_range(0, 39) == 0) pulse_inv();
            access(we, byt, addr, $urandom, -1, 1'b0, st);
            last_addr = addr;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
